serial_borrow_subtractor_4bit: RTL

- Bit-serial subtractor computing diff = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- It is the inverse-operation counterpart of the 4-bit ripple-carry adder, in the same arithmetic datapath family.
- Trades area for latency; a start/busy/done handshake hands operands in and results out.

---
 rtl/sub_pkg.sv | 18 +
 rtl/full_subtractor_1bit.sv | 14 +
 rtl/serial_borrow_subtractor_4bit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and a
// constant-foldable ceil(log2) used to size the bit counter.
package sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor x - y - bi; purely combinational, zero latency.
// No handshake or backpressure; it is the arithmetic cell of the serial loop.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_borrow_subtractor_4bit.sv
// Bit-serial a - b - bin, LSB first; result WIDTH+1 cycles after start, with no backpressure.
// start is ignored while busy; SUB_OVERFLOW_FLAG_EN adds a registered two's-complement ovf output.
module serial_borrow_subtractor_4bit
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_nxt;

    full_subtractor_1bit u_fs (
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_diff_nxt = {w_d, r_diff_sh[WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_SHIFT);
        done = (r_state == ST_DONE);
    end

    // Result registers load only on the last shift so diff never shows a partial value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
            r_bout    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_borrow  <= w_bo;
                    r_diff_sh <= w_diff_nxt;
                    r_cnt     <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff <= w_diff_nxt;
                        r_bout <= w_bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SUB_OVERFLOW_FLAG_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits are shifted out of r_a_sh/r_b_sh, so keep them aside.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (r_state == ST_SHIFT && w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_diff_nxt[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
